// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction-memory address from the PC, captures read data one clock
// later and hands {instr, pc} to decode through a 2-entry FIFO with a valid/ready handshake.
module instruction_fetch #(
    parameter int unsigned       WIDTH1   = 32,
    parameter logic [WIDTH1-1:0] RESET_PC = '0,
    parameter logic [WIDTH1-1:0] PC_STEP  = WIDTH1'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              redirect,
    input  logic [WIDTH1-1:0] redirect_pc,
    output logic [WIDTH1-1:0] imem_addr,
    input  logic [WIDTH1-1:0] imem_rdata,
    output logic [WIDTH1-1:0] instr,
    output logic [WIDTH1-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    // Handshake: decode takes the head on any clock where instr_valid & instr_ready are both high;
    // the head stays stable while instr_valid is high and instr_ready is low.

    logic [WIDTH1-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [WIDTH1-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]        count_q, count_d;
    logic [WIDTH1-1:0] slot0_instr_q, slot0_instr_d;
    logic [WIDTH1-1:0] slot0_pc_q, slot0_pc_d;
    logic [WIDTH1-1:0] slot1_instr_q, slot1_instr_d;
    logic [WIDTH1-1:0] slot1_pc_q, slot1_pc_d;

    logic       pop;
    logic       issue;
    logic [2:0] occupancy;
    logic [1:0] kept;

    assign imem_addr   = pc_q;
    assign instr       = slot0_instr_q;
    assign instr_pc    = slot0_pc_q;
    assign instr_valid = (count_q != 2'd0);

    assign pop  = instr_valid & instr_ready;
    assign kept = count_q - {1'b0, pop};

    // An in-flight read already owns a buffer slot, so it is counted before allowing a new issue.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = en & ~redirect & (occupancy < 3'd2);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        slot0_instr_d = slot0_instr_q;
        slot0_pc_d    = slot0_pc_q;
        slot1_instr_d = slot1_instr_q;
        slot1_pc_d    = slot1_pc_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_STEP;
            end
            if (pop) begin
                slot0_instr_d = slot1_instr_q;
                slot0_pc_d    = slot1_pc_q;
            end
            // The returning word lands right behind whatever survives this cycle's pop.
            if (inflight_q) begin
                if (kept == 2'd0) begin
                    slot0_instr_d = imem_rdata;
                    slot0_pc_d    = inflight_pc_q;
                end else begin
                    slot1_instr_d = imem_rdata;
                    slot1_pc_d    = inflight_pc_q;
                end
            end
            count_d = kept + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            slot0_instr_q <= '0;
            slot0_pc_q    <= '0;
            slot1_instr_q <= '0;
            slot1_pc_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            slot0_instr_q <= slot0_instr_d;
            slot0_pc_q    <= slot0_pc_d;
            slot1_instr_q <= slot1_instr_d;
            slot1_pc_q    <= slot1_pc_d;
        end
    end

endmodule
